// File: rtl/decode.sv
// decode: second pipeline stage, directly downstream of fetch.
// Decodes one MIPS-style instruction word per enable pulse into register
// indices, an extended immediate, an ALU operation and control flags. Results
// are registered and presented one cycle later with a one-cycle done pulse.
// A load-use hazard against the previously issued slot produces one bubble
// slot while the instruction waits in a hold buffer, then it is replayed.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   enable           command/pc valid this cycle
//   flush            drop held and in-flight instruction
//   pc, command      instruction address and word
//   done             one-cycle pulse, decoded outputs valid
//   stall            held instruction awaiting replay; upstream must wait
//   bubble           slot is a no-op (all control flags 0)
//   d_pc             PC of the decoded instruction
//   rs, rt, rd       register indices (rd = 0 when nothing is written)
//   imm, shamt       extended immediate, shift amount
//   alu_op           ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLT=5 SLL=6 SRL=7 SRA=8 LUI=9
//   use_imm .. illegal  control flags
module decode (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        flush,
  input  logic [31:0] pc,
  input  logic [31:0] command,
  output logic        done,
  output logic        stall,
  output logic        bubble,
  output logic [31:0] d_pc,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [4:0]  shamt,
  output logic [3:0]  alu_op,
  output logic        use_imm,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        branch,
  output logic        bne,
  output logic        jump,
  output logic        jump_reg,
  output logic        link,
  output logic        illegal
);

  localparam logic [3:0] AluAdd = 4'd0;
  localparam logic [3:0] AluSub = 4'd1;
  localparam logic [3:0] AluAnd = 4'd2;
  localparam logic [3:0] AluOr  = 4'd3;
  localparam logic [3:0] AluXor = 4'd4;
  localparam logic [3:0] AluSlt = 4'd5;
  localparam logic [3:0] AluSll = 4'd6;
  localparam logic [3:0] AluSrl = 4'd7;
  localparam logic [3:0] AluSra = 4'd8;
  localparam logic [3:0] AluLui = 4'd9;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        use_imm;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        branch;
    logic        bne;
    logic        jump;
    logic        jump_reg;
    logic        link;
    logic        illegal;
    logic        bubble;
    logic        reads_rs;
    logic        reads_rt;
  } dec_t;

  // Hold buffer and load tracker
  logic [31:0] hold_cmd_q, hold_pc_q;
  logic        load_valid_q;
  logic [4:0]  load_reg_q;

  // While stalled the held instruction is the one decoded, whatever is on the inputs
  logic [31:0] src_cmd, src_pc;
  assign src_cmd = stall ? hold_cmd_q : command;
  assign src_pc  = stall ? hold_pc_q  : pc;

  dec_t        dec;
  logic [5:0]  op, fn;
  logic [31:0] sext16, zext16, jtarget;
  logic        bad;
  logic        hazard;

  assign op      = src_cmd[31:26];
  assign fn      = src_cmd[5:0];
  assign sext16  = {{16{src_cmd[15]}}, src_cmd[15:0]};
  assign zext16  = {16'h0, src_cmd[15:0]};
  assign jtarget = {4'b0, src_cmd[25:0], 2'b00};

  always_comb begin
    dec    = '0;
    bad    = 1'b0;
    dec.rs = src_cmd[25:21];
    dec.rt = src_cmd[20:16];
    if (src_cmd == 32'h0000_0000 || src_cmd == 32'hFFFF_FFFF) begin
      dec.bubble = 1'b1;
    end else begin
      case (op)
        6'h00: begin
          dec.rd       = src_cmd[15:11];
          dec.reg_write = 1'b1;
          dec.reads_rs = 1'b1;
          dec.reads_rt = 1'b1;
          case (fn)
            6'h21: dec.alu_op = AluAdd;
            6'h23: dec.alu_op = AluSub;
            6'h24: dec.alu_op = AluAnd;
            6'h25: dec.alu_op = AluOr;
            6'h26: dec.alu_op = AluXor;
            6'h2A: dec.alu_op = AluSlt;
            6'h00: begin dec.alu_op = AluSll; dec.reads_rs = 1'b0; end
            6'h02: begin dec.alu_op = AluSrl; dec.reads_rs = 1'b0; end
            6'h03: begin dec.alu_op = AluSra; dec.reads_rs = 1'b0; end
            6'h08: begin
              dec.rd        = 5'd0;
              dec.reg_write = 1'b0;
              dec.jump      = 1'b1;
              dec.jump_reg  = 1'b1;
            end
            6'h09: begin
              dec.jump     = 1'b1;
              dec.jump_reg = 1'b1;
              dec.link     = 1'b1;
            end
            default: bad = 1'b1;
          endcase
        end
        6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
          dec.rd        = src_cmd[20:16];
          dec.use_imm   = 1'b1;
          dec.reg_write = 1'b1;
          dec.reads_rs  = 1'b1;
          case (op)
            6'h09:   begin dec.alu_op = AluAdd; dec.imm = sext16; end
            6'h0A:   begin dec.alu_op = AluSlt; dec.imm = sext16; end
            6'h0C:   begin dec.alu_op = AluAnd; dec.imm = zext16; end
            6'h0D:   begin dec.alu_op = AluOr;  dec.imm = zext16; end
            6'h0E:   begin dec.alu_op = AluXor; dec.imm = zext16; end
            default: begin
              dec.alu_op   = AluLui;
              dec.imm      = {src_cmd[15:0], 16'h0};
              dec.reads_rs = 1'b0;
            end
          endcase
        end
        6'h23: begin
          dec.mem_read  = 1'b1;
          dec.rd        = src_cmd[20:16];
          dec.reg_write = 1'b1;
          dec.use_imm   = 1'b1;
          dec.imm       = sext16;
          dec.reads_rs  = 1'b1;
        end
        6'h2B: begin
          dec.mem_write = 1'b1;
          dec.use_imm   = 1'b1;
          dec.imm       = sext16;
          dec.reads_rs  = 1'b1;
          dec.reads_rt  = 1'b1;
        end
        6'h04, 6'h05: begin
          dec.branch   = 1'b1;
          dec.bne      = op[0];
          dec.alu_op   = AluSub;
          dec.imm      = {sext16[29:0], 2'b00};
          dec.reads_rs = 1'b1;
          dec.reads_rt = 1'b1;
        end
        6'h02: begin
          dec.jump = 1'b1;
          dec.imm  = jtarget;
        end
        6'h03: begin
          dec.jump      = 1'b1;
          dec.imm       = jtarget;
          dec.link      = 1'b1;
          dec.rd        = 5'd31;
          dec.reg_write = 1'b1;
        end
        6'h32: begin
          dec.jump = 1'b1;
          dec.imm  = src_pc + jtarget;
        end
        default: bad = 1'b1;
      endcase
    end
    if (bad) begin
      dec         = '0;
      dec.rs      = src_cmd[25:21];
      dec.rt      = src_cmd[20:16];
      dec.illegal = 1'b1;
      dec.bubble  = 1'b1;
    end
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
  end

  assign hazard = load_valid_q &&
                  ((dec.reads_rs && dec.rs == load_reg_q) ||
                   (dec.reads_rt && dec.rt == load_reg_q));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done         <= 1'b0;
      stall        <= 1'b0;
      bubble       <= 1'b0;
      d_pc         <= '0;
      rs           <= '0;
      rt           <= '0;
      rd           <= '0;
      imm          <= '0;
      shamt        <= '0;
      alu_op       <= '0;
      use_imm      <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      reg_write    <= 1'b0;
      branch       <= 1'b0;
      bne          <= 1'b0;
      jump         <= 1'b0;
      jump_reg     <= 1'b0;
      link         <= 1'b0;
      illegal      <= 1'b0;
      hold_cmd_q   <= '0;
      hold_pc_q    <= '0;
      load_valid_q <= 1'b0;
      load_reg_q   <= '0;
    end else if (flush) begin
      // Decoded outputs deliberately keep their last values
      done         <= 1'b0;
      stall        <= 1'b0;
      hold_cmd_q   <= '0;
      hold_pc_q    <= '0;
      load_valid_q <= 1'b0;
    end else if (stall || enable) begin
      done  <= 1'b1;
      d_pc  <= src_pc;
      shamt <= src_cmd[10:6];
      if (!stall && hazard) begin
        // Issue a no-op slot and park the instruction for replay next cycle
        stall        <= 1'b1;
        hold_cmd_q   <= command;
        hold_pc_q    <= pc;
        bubble       <= 1'b1;
        rs           <= '0;
        rt           <= '0;
        rd           <= '0;
        imm          <= '0;
        alu_op       <= '0;
        use_imm      <= 1'b0;
        mem_read     <= 1'b0;
        mem_write    <= 1'b0;
        reg_write    <= 1'b0;
        branch       <= 1'b0;
        bne          <= 1'b0;
        jump         <= 1'b0;
        jump_reg     <= 1'b0;
        link         <= 1'b0;
        illegal      <= 1'b0;
        load_valid_q <= 1'b0;
      end else begin
        stall        <= 1'b0;
        bubble       <= dec.bubble;
        rs           <= dec.rs;
        rt           <= dec.rt;
        rd           <= dec.rd;
        imm          <= dec.imm;
        alu_op       <= dec.alu_op;
        use_imm      <= dec.use_imm;
        mem_read     <= dec.mem_read;
        mem_write    <= dec.mem_write;
        reg_write    <= dec.reg_write;
        branch       <= dec.branch;
        bne          <= dec.bne;
        jump         <= dec.jump;
        jump_reg     <= dec.jump_reg;
        link         <= dec.link;
        illegal      <= dec.illegal;
        load_valid_q <= dec.mem_read && (dec.rt != 5'd0);
        load_reg_q   <= dec.rt;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: doc/decode.md
# decode

Second pipeline stage of the core, directly downstream of fetch. It accepts one instruction word and its PC per `enable` pulse and decodes the MIPS-style encoding into register indices, an extended immediate, an ALU operation and control flags. Results are presented one cycle later with a one-cycle `done` pulse. It detects load-use hazards against the previously issued instruction and inserts exactly one bubble, replaying the held instruction automatically.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `enable`  in  1  `command`/`pc` valid this cycle (driven from fetch `done`).
- `flush`  in  1  discard the held and in-flight instruction (branch redirect).
- `pc`  in  32  PC of `command`.
- `command`  in  32  instruction word.
- `done`  out  1  one-cycle pulse: decoded outputs valid.
- `stall`  out  1  high while a held instruction awaits replay; upstream must not pulse `enable`.
- `bubble`  out  1  with `done`: slot is a no-op (all control flags 0).
- `d_pc`  out  32  PC of the decoded instruction.
- `rs`, `rt`  out  5  source register indices.
- `rd`  out  5  destination index: 0 if no write.
- `imm`  out  32  extended immediate.
- `shamt`  out  5  `command[10:6]`.
- `alu_op`  out  4  ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLL=6, SRL=7, SRA=8, LUI=9.
- `use_imm`, `mem_read`, `mem_write`, `reg_write`, `branch`, `bne`, `jump`, `jump_reg`, `link`, `illegal`  out  1 each  control flags.

## Operation
- Reset: every output is 0, the hold buffer is empty, and the load tracker is cleared.
- Opcode 0x00 (R-type), selected by funct:
  - ADDU 0x21, SUBU 0x23, AND 0x24, OR 0x25, XOR 0x26, SLT 0x2A: `rd`=cmd[15:11], `reg_write`=1.
  - SLL 0x00, SRL 0x02, SRA 0x03: same as above; `rs` still reported.
  - JR 0x08: `jump`=1, `jump_reg`=1.
  - JALR 0x09: `jump`=1, `jump_reg`=1, `link`=1, `rd`=cmd[15:11].
- I-type:
  - ADDIU 0x09 and SLTI 0x0A: sign-extended immediate.
  - ANDI 0x0C, ORI 0x0D, XORI 0x0E: zero-extended immediate.
  - LUI 0x0F: `imm`={cmd[15:0],16'h0}.
  - All of these: `rd`=cmd[20:16], `use_imm`=1, `reg_write`=1.
- Memory:
  - LW 0x23: `mem_read`=1, `rd`=rt, `reg_write`=1.
  - SW 0x2B: `mem_write`=1, `rd`=0.
  - Both: ADD with sign-extended immediate.
- Branches:
  - BEQ 0x04 and BNE 0x05: `branch`=1, SUB, `imm`=sext(cmd[15:0])<<2.
  - BNE also sets `bne`=1.
- Jumps:
  - J 0x02: `jump`=1, `imm`={4'b0,cmd[25:0],2'b00}.
  - JAL 0x03: as J, plus `link`=1 and `rd`=31.
  - BC 0x32: `jump`=1, `imm`=`d_pc`+{4'b0,cmd[25:0],2'b00} (32-bit wrap).
- `rd` of 0 forces `reg_write`=0.
- NOP and bubble words: `command`=0x00000000 (SLL $0) and 0xFFFFFFFF both decode as `bubble`=1.
- Any other encoding sets `illegal`=1, `bubble`=1, and all other control flags 0.
- Hazard check:
  - A hazard exists when the last issued non-bubble slot was LW to register L≠0 and the new instruction reads L.
  - An instruction reads `rs` unless it is J/JAL/BC/LUI/shift.
  - An instruction reads `rt` for R-type, SW, BEQ and BNE.
- On a hazard:
  - Issue a bubble slot.
  - Latch `command`/`pc` into the hold buffer and raise `stall`.
  - The next cycle re-issues the held instruction, which now finds no hazard, and clears `stall`.
- The load tracker updates on every `done`:
  - It holds L after a LW slot.
  - It clears after any other slot, including a bubble.

## Timing
- Latency: `enable` at cycle N gives `done`=1 at N+1 with registered outputs. `done` is 0 otherwise.
- Hazard timeline (`enable` at N):
  - N+1: `done`=1, `bubble`=1, `stall`=1.
  - N+2: `done`=1 with the real decode, `stall`=0.
- Back-to-back `enable` every cycle is supported with no hazard, giving one `done` per cycle.
- `enable` while `stall`=1 is ignored; the held instruction wins.
- `flush` has priority over `enable` and replay:
  - The next cycle gives no `done`.
  - `stall` is 0, the hold buffer is emptied, and the tracker is cleared.
  - Outputs keep their last values.
- `flush` and `enable` in the same cycle: the instruction is dropped.
- `rstn` low mid-replay: everything returns to reset values immediately, asynchronously.

## Test plan
- Reset release then `enable` with 0x00851021 (ADDU $2,$4,$5), pc=0x100 -> next cycle: `done`=1, `rs`=4, `rt`=5, `rd`=2, `alu_op`=0, `reg_write`=1, `d_pc`=0x100.
- 0x2408FFFF (ADDIU $8,$0,-1) -> `imm`=0xFFFFFFFF, `use_imm`=1. 0x3408FFFF (ORI) -> `imm`=0x0000FFFF, `alu_op`=3.
- LW $3,0($4) then ADDU $2,$3,$5 on consecutive cycles -> three `done` pulses: LW, then bubble with `stall`=1, then ADDU; `rs`=3 in the last.
- LW $3 then J 0x40 -> no stall; J gives `jump`=1, `imm`=0x00000100. BC offset 4 at pc=0x200 -> `imm`=0x210.
- Hazard stall, then `flush` during the `stall` cycle -> no ADDU `done`, `stall`=0. The next `enable` decodes normally with no hazard.
- 0xFFFFFFFF -> `bubble`=1, `illegal`=0. Opcode 0x3F -> `illegal`=1, `bubble`=1, `reg_write`=0.
